lcd_init_seq: RTL and testbench



---
 rtl/lcd_init_seq.sv | 136 +++++++++++++
 tb/tb_lcd_init_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lcd_init_seq.sv
// HD44780-style power-on initialisation sequencer: power-up wait, four timed writes, then hands the bus over.
// Optional LCD_INIT_RESTART_EN adds a restart input that re-runs the writes from DONE.
module lcd_init_seq #(
    parameter int BUS_W     = 4,
    parameter int CNT_W     = 20,
    parameter int T_POWERUP = 750000,
    parameter int T_SU      = 2,
    parameter int T_PULSE   = 12,
    parameter int T_WAIT0   = 205000,
    parameter int T_WAIT1   = 5000,
    parameter int T_WAIT2   = 2000,
    parameter int T_WAIT3   = 2000
) (
    input  logic             clk,
    input  logic             reset,
`ifdef LCD_INIT_RESTART_EN
    input  logic             restart,
`endif
    output logic             enable,
    output logic             LCD_E,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic [BUS_W-1:0] db
);

    typedef enum logic [3:0] {
        POWERUP = 4'd0,
        SETUP_0, PULSE_0, WAIT_0,
        SETUP_1, PULSE_1, WAIT_1,
        SETUP_2, PULSE_2, WAIT_2,
        SETUP_3, PULSE_3, WAIT_3,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, limit;
    logic             restart_req;
    logic             e_next, en_next;
    logic [3:0]       nib;
    logic [BUS_W-1:0] db_next;

`ifdef LCD_INIT_RESTART_EN
    assign restart_req = restart;
`else
    assign restart_req = 1'b0;
`endif

    assign LCD_RS = 1'b0;
    assign LCD_RW = 1'b0;

    always_comb begin
        limit = '0;
        case (state)
            POWERUP:                            limit = CNT_W'(T_POWERUP - 1);
            SETUP_0, SETUP_1, SETUP_2, SETUP_3: limit = CNT_W'(T_SU - 1);
            PULSE_0, PULSE_1, PULSE_2, PULSE_3: limit = CNT_W'(T_PULSE - 1);
            WAIT_0:                             limit = CNT_W'(T_WAIT0 - 1);
            WAIT_1:                             limit = CNT_W'(T_WAIT1 - 1);
            WAIT_2:                             limit = CNT_W'(T_WAIT2 - 1);
            WAIT_3:                             limit = CNT_W'(T_WAIT3 - 1);
            default:                            limit = '0;
        endcase
    end

    // Timed states are enumerated in sequence order, so advancing is a +1 on the encoding.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        case (state)
            DONE: begin
                cnt_next = '0;
                if (restart_req) state_next = SETUP_0;
            end
            POWERUP,
            SETUP_0, PULSE_0, WAIT_0,
            SETUP_1, PULSE_1, WAIT_1,
            SETUP_2, PULSE_2, WAIT_2,
            SETUP_3, PULSE_3, WAIT_3: begin
                if (cnt == limit) begin
                    cnt_next   = '0;
                    state_next = state_t'(state + 4'd1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = POWERUP;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers change together with the state.
    always_comb begin
        e_next  = 1'b0;
        en_next = 1'b0;
        nib     = 4'h0;
        case (state_next)
            SETUP_0, WAIT_0, SETUP_1, WAIT_1, SETUP_2, WAIT_2: nib = 4'h3;
            PULSE_0, PULSE_1, PULSE_2: begin
                nib    = 4'h3;
                e_next = 1'b1;
            end
            SETUP_3, WAIT_3: nib = (BUS_W == 8) ? 4'h3 : 4'h2;
            PULSE_3: begin
                nib    = (BUS_W == 8) ? 4'h3 : 4'h2;
                e_next = 1'b1;
            end
            DONE:    en_next = 1'b1;
            default: nib = 4'h0;
        endcase
    end

    generate
        if (BUS_W == 8) begin : g_bus8
            assign db_next = {nib, 4'h0};
        end else begin : g_bus4
            assign db_next = nib;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= POWERUP;
            cnt    <= '0;
            enable <= 1'b0;
            LCD_E  <= 1'b0;
            db     <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            enable <= en_next;
            LCD_E  <= e_next;
            db     <= db_next;
        end
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Random reset/restart stimulus on 4-bit and 8-bit instances, checked against a timeline model
// that derives outputs from the elapsed cycle count of the init sequence.
module tb_lcd_init_seq;

    localparam int TP  = 10;
    localparam int TSU = 2;
    localparam int TPU = 3;
    localparam int TW0 = 5;
    localparam int TW1 = 7;
    localparam int TW2 = 4;
    localparam int TW3 = 6;
    localparam int TOTAL = TP + 4 * (TSU + TPU) + TW0 + TW1 + TW2 + TW3;
`ifdef LCD_INIT_RESTART_EN
    localparam bit RST_EN = 1'b1;
`else
    localparam bit RST_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       en4, e4, rs4, rw4;
    logic [3:0] db4;
    logic       en8, e8, rs8, rw8;
    logic [7:0] db8;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    always #5 clk = ~clk;

    lcd_init_seq #(
        .BUS_W(4), .CNT_W(8), .T_POWERUP(TP), .T_SU(TSU), .T_PULSE(TPU),
        .T_WAIT0(TW0), .T_WAIT1(TW1), .T_WAIT2(TW2), .T_WAIT3(TW3)
    ) u_dut4 (
        .clk(clk), .reset(reset),
`ifdef LCD_INIT_RESTART_EN
        .restart(restart),
`endif
        .enable(en4), .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .db(db4)
    );

    lcd_init_seq #(
        .BUS_W(8), .CNT_W(8), .T_POWERUP(TP), .T_SU(TSU), .T_PULSE(TPU),
        .T_WAIT0(TW0), .T_WAIT1(TW1), .T_WAIT2(TW2), .T_WAIT3(TW3)
    ) u_dut8 (
        .clk(clk), .reset(reset),
`ifdef LCD_INIT_RESTART_EN
        .restart(restart),
`endif
        .enable(en8), .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .db(db8)
    );

    // Elapsed cycles into the sequence; restart from DONE skips the power-up wait.
    always @(posedge clk) begin
        if (reset)                               t <= 0;
        else if (RST_EN && restart && t >= TOTAL) t <= TP;
        else if (t < TOTAL)                      t <= t + 1;
    end

    function automatic void expect_at(input int tt, input bit bus8,
                                      output logic e, output logic [7:0] d, output logic en);
        int tw[4];
        int u;
        int span;
        bit found;
        logic [7:0] nibv;
        tw    = '{TW0, TW1, TW2, TW3};
        e     = 1'b0;
        d     = 8'h00;
        en    = 1'b0;
        found = 1'b0;
        if (tt >= TOTAL) begin
            en = 1'b1;
        end else if (tt >= TP) begin
            u = tt - TP;
            for (int k = 0; k < 4; k++) begin
                span = TSU + TPU + tw[k];
                if (!found) begin
                    if (u < span) begin
                        found = 1'b1;
                        e     = (u >= TSU) && (u < TSU + TPU);
                        nibv  = (k == 3 && !bus8) ? 8'h02 : 8'h03;
                        d     = bus8 ? (nibv << 4) : nibv;
                    end else begin
                        u = u - span;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic compare_all();
        logic       e, en;
        logic [7:0] d;
        expect_at(t, 1'b0, e, d, en);
        check("e4",  32'(e4),  32'(e));
        check("db4", 32'(db4), 32'(d));
        check("en4", 32'(en4), 32'(en));
        check("rs4", 32'(rs4), 32'd0);
        check("rw4", 32'(rw4), 32'd0);
        expect_at(t, 1'b1, e, d, en);
        check("e8",  32'(e8),  32'(e));
        check("db8", 32'(db8), 32'(d));
        check("en8", 32'(en8), 32'(en));
        check("rs8", 32'(rs8), 32'd0);
        check("rw8", 32'(rw8), 32'd0);
    endtask

    task automatic run_cycle(input logic rst, input logic rs);
        reset   = rst;
        restart = rs;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        // Reset for 3 cycles, then one full sequence plus idle time in DONE.
        repeat (3) run_cycle(1'b1, 1'b0);
        repeat (TOTAL + 10) run_cycle(1'b0, 1'b0);

        // Abort in the middle of the third E pulse; the full power-up wait must repeat.
        run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 2 * TOTAL && t != TP + 2 * (TSU + TPU) + TW0 + TW1 + TSU + 1; i++)
            run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        repeat (TOTAL + 5) run_cycle(1'b0, 1'b0);

        // Restart pulse from DONE, then a pulse while mid-sequence.
        run_cycle(1'b0, 1'b1);
        repeat (TP + TSU + TPU + 2) run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b1);
        repeat (TOTAL + 5) run_cycle(1'b0, 1'b0);

        for (int i = 0; i < 3000; i++)
            run_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
